// File: rtl/mtr_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mtr_drv_pkg
// Description : Shared constants for the dual H-bridge PWM motor driver.
// Revision    : 1.0 - initial release
// ============================================================================
package mtr_drv_pkg;

    // Default dead-time between one side of a pair falling and the other rising
    localparam int unsigned NONOVERLAP_DEFAULT = 32;

    // Offset that maps signed speed -1024..+1023 onto unsigned duty 0..2047
    localparam logic [10:0] DUTY_OFFSET = 11'h400;

    // Terminal count of the shared 2048-clock period counter
    localparam logic [10:0] PERIOD_MAX = 11'h7FF;

    // Width of the per-side dead-time counter (holds 1..63)
    localparam int unsigned DT_W = 6;

endpackage
`default_nettype wire

// File: rtl/pwm11.sv
`default_nettype none
// ============================================================================
// Module      : pwm11
// Description : One H-bridge channel: period-synchronous duty shadow, raw PWM
//               compare, edge detect and dead-time insertion producing a
//               complementary high-side / low-side drive pair.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm11
    import mtr_drv_pkg::*;
#(
    parameter int unsigned NONOVERLAP = NONOVERLAP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] i_cnt,
    input  logic [10:0] i_spd,
    output logic        o_pwm1,
    output logic        o_pwm2
);

    localparam logic [DT_W-1:0] c_dt_max = DT_W'(NONOVERLAP);

    logic [10:0]     r_duty;
    logic            r_pwm_raw;
    logic            r_pwm_prev;
    logic [DT_W-1:0] r_dt;
    logic            r_pwm1;
    logic            r_pwm2;

    logic            w_change;
    logic [DT_W-1:0] w_dt_next;

    assign w_change = r_pwm_raw ^ r_pwm_prev;

    // Next dead-time count: restart on an edge of the raw PWM, else count up and hold at the limit
    always_comb begin
        w_dt_next = r_dt;
        if (w_change) begin
            w_dt_next = '0;
        end else if (r_dt != c_dt_max) begin
            w_dt_next = r_dt + {{(DT_W-1){1'b0}}, 1'b1};
        end
    end

    // Duty shadow, raw compare, edge history, dead-time counter and drive outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty     <= DUTY_OFFSET;
            r_pwm_raw  <= 1'b0;
            r_pwm_prev <= 1'b0;
            r_dt       <= '0;
            r_pwm1     <= 1'b0;
            r_pwm2     <= 1'b0;
        end else begin
            // New speed only takes effect at a period boundary
            if (i_cnt == PERIOD_MAX) begin
                r_duty <= i_spd + DUTY_OFFSET;
            end
            r_pwm_raw  <= (i_cnt < r_duty);
            r_pwm_prev <= r_pwm_raw;
            r_dt       <= w_dt_next;
            // Drive is enabled on the edge the counter reaches the limit, so the
            // both-low gap after each raw edge is exactly NONOVERLAP clocks.
            if (!w_change && (w_dt_next == c_dt_max)) begin
                r_pwm1 <= r_pwm_raw;
                r_pwm2 <= ~r_pwm_raw;
            end else begin
                r_pwm1 <= 1'b0;
                r_pwm2 <= 1'b0;
            end
        end
    end

    assign o_pwm1 = r_pwm1;
    assign o_pwm2 = r_pwm2;

endmodule
`default_nettype wire

// File: rtl/mtr_drv.sv
`default_nettype none
// ============================================================================
// Module      : mtr_drv
// Description : Dual motor driver. A shared 11-bit free-running period counter
//               feeds two independent pwm11 channels (left and right wheel).
// Revision    : 1.0 - initial release
// ============================================================================
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int unsigned NONOVERLAP = NONOVERLAP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        lftPWM1,
    output logic        lftPWM2,
    output logic        rghtPWM1,
    output logic        rghtPWM2
);

    logic [10:0] r_cnt;

    // Free-running period counter, wraps 0x7FF -> 0x000 every 2048 clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 11'd1;
        end
    end

    pwm11 #(
        .NONOVERLAP (NONOVERLAP)
    ) u_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cnt  (r_cnt),
        .i_spd  (lft_spd),
        .o_pwm1 (lftPWM1),
        .o_pwm2 (lftPWM2)
    );

    pwm11 #(
        .NONOVERLAP (NONOVERLAP)
    ) u_rght (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cnt  (r_cnt),
        .i_spd  (rght_spd),
        .o_pwm1 (rghtPWM1),
        .o_pwm2 (rghtPWM2)
    );

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_mtr_drv
// Description : Self-checking bench for mtr_drv. A run-length reference model
//               predicts every output each cycle; table rows check per-period
//               high-time counts; hand sequences cover mid-period speed change
//               and asynchronous reset; a random phase stresses dead-time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtr_drv;
    import mtr_drv_pkg::*;

    localparam int N   = 32;
    localparam int PER = 2048;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [10:0] lft_spd  = 11'h000;
    logic [10:0] rght_spd = 11'h000;
    logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mtr_drv #(
        .NONOVERLAP (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw PWM is the period position compared against a duty that is latched
    // once per period. A drive output is asserted only when the raw level has
    // been unchanged for at least N+1 consecutive samples; reset behaves as if
    // two low samples had just been seen.
    int m_cnt     = 0;
    int m_duty[2] = '{1024, 1024};
    bit m_raw[2]  = '{1'b0, 1'b0};
    int m_run[2]  = '{2, 2};
    bit m_p1[2]   = '{1'b0, 1'b0};
    bit m_p2[2]   = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            for (int s = 0; s < 2; s++) begin
                m_duty[s] = 1024;
                m_raw[s]  = 1'b0;
                m_run[s]  = 2;
                m_p1[s]   = 1'b0;
                m_p2[s]   = 1'b0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                bit          nr;
                bit          settled;
                logic [10:0] spd;
                spd     = (s == 0) ? lft_spd : rght_spd;
                nr      = (m_cnt < m_duty[s]);
                settled = (m_run[s] >= N + 1);
                m_p1[s] = settled && m_raw[s];
                m_p2[s] = settled && !m_raw[s];
                if (nr == m_raw[s]) m_run[s] = (m_run[s] < 4 * PER) ? m_run[s] + 1 : m_run[s];
                else                m_run[s] = 1;
                m_raw[s] = nr;
                if (m_cnt == PER - 1) m_duty[s] = int'($signed(spd)) + 1024;
            end
            m_cnt = (m_cnt + 1) % PER;
        end
    end

    // Cycle-by-cycle comparison against the model plus the non-overlap rule
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_lft",    int'({lftPWM1, lftPWM2}),   int'({m_p1[0], m_p2[0]}));
            check("model_rght",   int'({rghtPWM1, rghtPWM2}), int'({m_p1[1], m_p2[1]}));
            check("overlap_lft",  int'(lftPWM1 & lftPWM2),    0);
            check("overlap_rght", int'(rghtPWM1 & rghtPWM2),  0);
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_cnt(input int c);
        int n;
        n = 0;
        @(negedge clk);
        while (m_cnt != c && n < 3 * PER) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != c) begin
            total++;
            bad++;
            $display("FAIL wait_cnt timeout: got %0d, want %0d", m_cnt, c);
        end
    endtask

    // Counts high samples of each output over 2048 consecutive cycles,
    // optionally changing lft_spd when the period position reaches chg_at.
    task automatic count_win(input int chg_at, input logic [10:0] chg_val,
                             output int l1, output int l2, output int r1, output int r2);
        l1 = 0; l2 = 0; r1 = 0; r2 = 0;
        for (int i = 0; i < PER; i++) begin
            l1 += int'(lftPWM1);
            l2 += int'(lftPWM2);
            r1 += int'(rghtPWM1);
            r2 += int'(rghtPWM2);
            if (m_cnt == chg_at) lft_spd = chg_val;
            @(negedge clk);
        end
    endtask

    function automatic logic [10:0] rnd_spd();
        int unsigned sel;
        int unsigned duty;
        sel = $urandom_range(0, 3);
        case (sel)
            0:       duty = $urandom_range(0, 63);
            1:       duty = $urandom_range(1984, 2047);
            default: duty = $urandom_range(0, 2047);
        endcase
        return 11'(int'(duty) - 1024);
    endfunction

    typedef struct {
        logic [10:0] l;
        logic [10:0] r;
        int          l1;
        int          l2;
        int          r1;
        int          r2;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int l1, l2, r1, r2, n;

        // duty = spd + 1024; per-period highs: PWM1 = max(d-N,0), PWM2 = max(2048-d-N,0), duty 0 -> PWM2 constant
        tbl[0] = '{11'h400, 11'h000,   0, 2048,  992,  992};
        tbl[1] = '{11'h000, 11'h3FF, 992,  992, 2015,    0};
        tbl[2] = '{11'h7E0, 11'h7FF, 960, 1024,  991,  993};
        tbl[3] = '{11'h41F, 11'h3EC,   0, 1985, 1996,    0};
        tbl[4] = '{11'h420, 11'h421,   0, 1984,    1, 1983};

        lft_spd  = tbl[0].l;
        rght_spd = tbl[0].r;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Steady-speed rows: skip a full period on the new duty, then count one
        for (int i = 0; i < 5; i++) begin
            lft_spd  = tbl[i].l;
            rght_spd = tbl[i].r;
            wait_cnt(0);
            wait_cnt(0);
            wait_cnt(16);
            count_win(-1, 11'h000, l1, l2, r1, r2);
            check($sformatf("row%0d_lftPWM1_high", i),  l1, tbl[i].l1);
            check($sformatf("row%0d_lftPWM2_high", i),  l2, tbl[i].l2);
            check($sformatf("row%0d_rghtPWM1_high", i), r1, tbl[i].r1);
            check($sformatf("row%0d_rghtPWM2_high", i), r2, tbl[i].r2);
        end

        // Mid-period speed change: current period keeps 50%, next uses duty 1280
        lft_spd = 11'h000;
        wait_cnt(0);
        wait_cnt(16);
        count_win(11'h200, 11'h100, l1, l2, r1, r2);
        check("midchg_cur_lftPWM1",  l1, 992);
        check("midchg_cur_lftPWM2",  l2, 992);
        count_win(-1, 11'h000, l1, l2, r1, r2);
        check("midchg_next_lftPWM1", l1, 1248);
        check("midchg_next_lftPWM2", l2, 736);

        // Asynchronous reset while lftPWM1 is high, then restart from counter 0
        lft_spd = 11'h000;
        wait_cnt(0);
        wait_cnt(11'h300);
        check("pre_reset_lftPWM1", int'(lftPWM1), 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lftPWM1 && n < 200);
        check("lftPWM1_first_rise_after_reset", n, N + 2);

        // Random speeds every clock, biased toward the duty extremes
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            lft_spd  = rnd_spd();
            rght_spd = rnd_spd();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
